fetch_stall_ctrl: RTL
=====================

FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

Interface
REQ-001 Parameter MAX_STALL, default 3: maximum consecutive stall cycles before the watchdog flags an error; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 PCWrite  input  1  from the hazard unit; 1 = PC may advance, 0 = hold PC.
REQ-005 IFIDWrite  input  1  from the hazard unit; 1 = IF/ID may load, 0 = hold IF/ID.
REQ-006 HazardMux  input  1  from the hazard unit; 1 = inject a bubble into ID/EX control.
REQ-007 branch_taken  input  1  redirect request, resolved this cycle.
REQ-008 branch_target  input  32  redirect address; bits [1:0] ignored and treated as 0.
REQ-009 instr_in  input  32  instruction word fetched at pc.
REQ-010 ctrl_in  input  10  decoded control bundle for the instruction in ID.
REQ-011 pc  output  32  current fetch address.
REQ-012 IFID_instr  output  32  IF/ID instruction register.
REQ-013 IFID_pc4  output  32  IF/ID copy of fetch address + 4.
REQ-014 IDEX_ctrl  output  10  ID/EX control register.
REQ-015 stall_active  output  1  registered; 1 while the FSM is in STALL.
REQ-016 stall_timeout  output  1  sticky watchdog error flag.
REQ-017 stall_count  output  16  count of stall cycles (see Configuration).

Function
REQ-018 PC update priority: branch_taken -> pc <= {branch_target[31:2],2'b00}; else PCWrite=1 -> pc <= pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0); else pc holds.
REQ-019 IF/ID update priority: branch_taken -> IFID_instr <= 0 (NOP) and IFID_pc4 <= 0; else IFIDWrite=1 -> IFID_instr <= instr_in, IFID_pc4 <= pc+4; else both hold.
REQ-020 ID/EX update: HazardMux=1 or branch_taken=1 -> IDEX_ctrl <= 0; else IDEX_ctrl <= ctrl_in; never holds.
REQ-021 PCWrite and IFIDWrite are acted on independently; mismatched values are not an error.
REQ-022 FSM states RUN and STALL; RUN->STALL when HazardMux=1 and branch_taken=0; STALL->RUN when HazardMux=0 or branch_taken=1; otherwise stay; stall_active=1 iff state is STALL.
REQ-023 4-bit run counter: cleared on entry to RUN; increments each cycle the FSM stays in STALL with HazardMux=1; saturates at 15.
REQ-024 When the run counter reaches MAX_STALL while the FSM is in STALL, stall_timeout is set to 1 on that edge; it then stays 1 until reset.
REQ-025 Latency: every output is registered; an input change is visible on outputs one edge later, with no combinational path from input to output.

Reset
REQ-026 While rst_n=0: pc=0, IFID_instr=0, IFID_pc4=0, IDEX_ctrl=0, FSM=RUN, run counter=0, stall_active=0, stall_timeout=0, stall_count=0.
REQ-027 Reset asserted mid-stall or mid-redirect aborts the operation immediately; the first edge after release behaves as if from RUN with all registers at their reset values.

Configuration
REQ-028 Macro STALL_COUNT_EN.
- Defined: stall_count increments by 1 on every edge where HazardMux=1 and rst_n=1; saturates at 16'hFFFF.
- Undefined: stall_count is constant 0 and no counter register exists.

Verification
REQ-029 Reset release, PCWrite=IFIDWrite=1, HazardMux=0, 4 cycles -> pc 0,4,8,12,16; IFID_pc4 trails pc by one cycle.
REQ-030 One stall cycle (PCWrite=IFIDWrite=0, HazardMux=1) at pc=8 -> pc and IFID held for 1 cycle; IDEX_ctrl=0 for that cycle; stall_active pulses for 1 cycle.
REQ-031 branch_taken=1 with target 32'h00000103 while HazardMux=1 -> pc=32'h100, IFID_instr=0, IDEX_ctrl=0, FSM stays in RUN.
REQ-032 MAX_STALL=3, HazardMux held at 1 for 5 cycles -> stall_timeout rises on the 4th stall edge and stays 1 after HazardMux falls; with STALL_COUNT_EN defined, stall_count=5.
REQ-033 pc=32'hFFFFFFFC, PCWrite=1 -> pc wraps to 0; rst_n pulsed low mid-stall -> all outputs return to reset values asynchronously.
REQ-034 STALL_COUNT_EN defined, 65540 stall cycles -> stall_count=16'hFFFF; STALL_COUNT_EN undefined -> stall_count=0 throughout.

Source files
------------

// File: rtl/fetch_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stall_ctrl_if
// Purpose  : Bundles the hazard-unit controls, the fetch/redirect inputs and
//            the pipeline-register outputs of fetch_stall_ctrl.
// Ports    : none (signal container)
//            slave  modport - used by fetch_stall_ctrl
//            master modport - used by the hazard unit / fetch side (or bench)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stall_ctrl_if;
    // Hazard unit controls
    logic        PCWrite;
    logic        IFIDWrite;
    logic        HazardMux;
    // Redirect and fetch data
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_in;
    logic [9:0]  ctrl_in;
    // Registered pipeline state
    logic [31:0] pc;
    logic [31:0] IFID_instr;
    logic [31:0] IFID_pc4;
    logic [9:0]  IDEX_ctrl;
    logic        stall_active;
    logic        stall_timeout;
    logic [15:0] stall_count;

    modport slave (
        input  PCWrite, IFIDWrite, HazardMux,
        input  branch_taken, branch_target, instr_in, ctrl_in,
        output pc, IFID_instr, IFID_pc4, IDEX_ctrl,
        output stall_active, stall_timeout, stall_count
    );

    modport master (
        output PCWrite, IFIDWrite, HazardMux,
        output branch_taken, branch_target, instr_in, ctrl_in,
        input  pc, IFID_instr, IFID_pc4, IDEX_ctrl,
        input  stall_active, stall_timeout, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stall_ctrl
// Purpose  : PC / IF-ID / ID-EX register control driven by the hazard unit,
//            with branch redirect, a RUN/STALL tracker and a stall watchdog.
// Ports    : clk   - single clock, rising edge
//            rst_n - asynchronous, active-low reset
//            bus   - fetch_stall_ctrl_if.slave
//                    in : PCWrite, IFIDWrite, HazardMux, branch_taken,
//                         branch_target, instr_in, ctrl_in
//                    out: pc, IFID_instr, IFID_pc4, IDEX_ctrl,
//                         stall_active, stall_timeout, stall_count
// Params   : MAX_STALL (1..15) - consecutive stall cycles before the
//            watchdog flag sets
// Macro    : STALL_COUNT_EN - when defined, stall_count is a saturating
//            16-bit count of HazardMux cycles; otherwise it is tied to 0
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stall_ctrl #(
    parameter int MAX_STALL = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fetch_stall_ctrl_if.slave bus
);

    localparam logic [3:0] c_max_stall = 4'(MAX_STALL);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [9:0]  idex_ctrl_q, idex_ctrl_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        stall_timeout_q, stall_timeout_d;

    logic [31:0] w_pc_plus4;
    logic        w_stall_req;

    // Address bits [1:0] of a redirect are forced to zero.
    logic        unused_target_bits;
    assign unused_target_bits = ^bus.branch_target[1:0];

    assign w_pc_plus4  = pc_q + 32'd4;
    // A redirect always wins over a stall request.
    assign w_stall_req = bus.HazardMux && !bus.branch_taken;

    // ------------------------------------------------------------------
    // Pipeline register next-state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;

        if (bus.branch_taken) begin
            pc_d = {bus.branch_target[31:2], 2'b00};
        end else if (bus.PCWrite) begin
            pc_d = w_pc_plus4;
        end

        if (bus.branch_taken) begin
            ifid_instr_d = 32'h0;
            ifid_pc4_d   = 32'h0;
        end else if (bus.IFIDWrite) begin
            ifid_instr_d = bus.instr_in;
            ifid_pc4_d   = w_pc_plus4;
        end

        // ID/EX is never held: either a bubble or the decoded bundle.
        if (bus.HazardMux || bus.branch_taken) begin
            idex_ctrl_d = 10'h0;
        end else begin
            idex_ctrl_d = bus.ctrl_in;
        end
    end

    // ------------------------------------------------------------------
    // RUN/STALL tracker and watchdog
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        run_cnt_d       = run_cnt_q;
        stall_timeout_d = stall_timeout_q;

        case (state_q)
            RUN: begin
                run_cnt_d = 4'd0;
                if (w_stall_req) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (w_stall_req) begin
                    // Remaining in STALL: extend the run, saturating.
                    if (run_cnt_q != 4'hF) begin
                        run_cnt_d = run_cnt_q + 4'd1;
                    end
                    if (run_cnt_d >= c_max_stall) begin
                        stall_timeout_d = 1'b1;
                    end
                end else begin
                    state_d   = RUN;
                    run_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d   = RUN;
                run_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= 32'h0;
            ifid_instr_q    <= 32'h0;
            ifid_pc4_q      <= 32'h0;
            idex_ctrl_q     <= 10'h0;
            state_q         <= RUN;
            run_cnt_q       <= 4'd0;
            stall_timeout_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc4_q      <= ifid_pc4_d;
            idex_ctrl_q     <= idex_ctrl_d;
            state_q         <= state_d;
            run_cnt_q       <= run_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall-cycle statistics counter
    // ------------------------------------------------------------------
`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (bus.HazardMux && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 16'h0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
`else
    assign bus.stall_count = 16'h0;
`endif

    // ------------------------------------------------------------------
    // Outputs: all taken straight from flops
    // ------------------------------------------------------------------
    assign bus.pc            = pc_q;
    assign bus.IFID_instr    = ifid_instr_q;
    assign bus.IFID_pc4      = ifid_pc4_q;
    assign bus.IDEX_ctrl     = idex_ctrl_q;
    assign bus.stall_active  = (state_q == STALL);
    assign bus.stall_timeout = stall_timeout_q;

endmodule
`default_nettype wire
